micro_ctrl: RTL and testbench

- Sequencing controller for the microwave timer datapath.
- Captures one-hot keypad digits into a 3-digit BCD time register (M:ST SO) and gates start, stop and door conditions.
- Runs a 1-second prescaler, decrements the time while cooking, and drives mag_on.
- The BCD digit outputs feed the existing 7-segment decoders, so this block replaces the ad-hoc control inside micro.

---
 rtl/micro_ctrl_if.sv | 32 +++
 rtl/micro_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_micro_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : micro_ctrl_if
// Brief    : Keypad / control-input / display-output bundle between the
//            microwave sequencing controller and its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
interface micro_ctrl_if;
  logic [9:0] keypad;        // one-hot digit keys, all zero = no key
  logic       startn;        // active-low start request
  logic       stopn;         // active-low stop/pause request
  logic       door_closed;   // 1 = door closed
  logic       mag_on;        // magnetron enable
  logic [3:0] min_bcd;       // minutes digit
  logic [3:0] sec_tens_bcd;  // tens-of-seconds digit
  logic [3:0] sec_ones_bcd;  // ones-of-seconds digit
  logic       done;          // high while cooking has completed
  logic [2:0] state;         // encoded controller state

  // Driver side: the environment feeding keys and requests
  modport master (
    output keypad, startn, stopn, door_closed,
    input  mag_on, min_bcd, sec_tens_bcd, sec_ones_bcd, done, state
  );

  // Controller side
  modport slave (
    input  keypad, startn, stopn, door_closed,
    output mag_on, min_bcd, sec_tens_bcd, sec_ones_bcd, done, state
  );
endinterface
`default_nettype wire

// File: rtl/micro_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : micro_ctrl
// Brief    : Microwave sequencing controller. Shifts one-hot keypad digits
//            into a 3-digit BCD time (M:ST SO), gates start/stop/door, runs
//            a one-second prescaler, counts the time down while cooking and
//            drives the magnetron enable.
// Revision : 1.0 - initial release
// ============================================================================
module micro_ctrl #(
  parameter int TICKS_PER_SEC = 100,  // clock cycles per one-second tick
  parameter int CNT_W         = 7     // prescaler width, 2**CNT_W >= TICKS_PER_SEC
) (
  input  logic         clock,
  input  logic         clearn,
  micro_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_TICK_LAST = CNT_W'(TICKS_PER_SEC - 1);

  // Registered state
  state_t           state_q,    state_d;
  logic [3:0]       min_q,      min_d;
  logic [3:0]       st_q,       st_d;
  logic [3:0]       so_q,       so_d;
  logic [CNT_W-1:0] presc_q,    presc_d;
  logic             mag_on_q,   mag_on_d;
  logic             done_q,     done_d;
  logic [9:0]       key_prev_q, key_prev_d;

  // Combinational helpers
  logic       key_onehot;
  logic       kp;
  logic [3:0] key_idx;
  logic       go;
  logic       pause_req;
  logic [3:0] dec_min;
  logic [3:0] dec_st;
  logic [3:0] dec_so;
  logic       dec_zero;
  logic       entry_nonzero;

  // Key-press event: a single key bit rising out of an all-released keypad.
  // Multi-bit codes never qualify, and a held key fires only once because
  // key_prev stays non-zero until the key is released.
  always_comb begin
    key_onehot = (bus.keypad != 10'd0) &&
                 ((bus.keypad & (bus.keypad - 10'd1)) == 10'd0);
    kp         = key_onehot && (key_prev_q == 10'd0);
  end

  // Binary index of the pressed key (meaningful only when key_onehot)
  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.keypad[i]) begin
        key_idx = 4'(i);
      end
    end
  end

  // Start and pause qualifiers
  always_comb begin
    go        = !bus.startn && bus.stopn && bus.door_closed;
    pause_req = !bus.door_closed || !bus.stopn;
  end

  // One-second decrement of the displayed time with BCD borrow; a minute
  // borrow reloads the seconds as 59 even if the tens digit was entered > 5.
  always_comb begin
    dec_min = min_q;
    dec_st  = st_q;
    dec_so  = so_q;
    if (so_q != 4'd0) begin
      dec_so = so_q - 4'd1;
    end else if (st_q != 4'd0) begin
      dec_st = st_q - 4'd1;
      dec_so = 4'd9;
    end else if (min_q != 4'd0) begin
      dec_min = min_q - 4'd1;
      dec_st  = 4'd5;
      dec_so  = 4'd9;
    end
    dec_zero = (dec_min == 4'd0) && (dec_st == 4'd0) && (dec_so == 4'd0);
  end

  // The shifted-in time is non-zero when any digit that survives the shift is
  always_comb begin
    entry_nonzero = (st_q != 4'd0) || (so_q != 4'd0) || (key_idx != 4'd0);
  end

  // Next-state, digit, prescaler and output computation
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    st_d       = st_q;
    so_d       = so_q;
    presc_d    = presc_q;
    mag_on_d   = 1'b0;
    done_d     = 1'b0;
    key_prev_d = bus.keypad;

    case (state_q)
      S_IDLE, S_ENTRY: begin
        // Start wins over a simultaneous key; IDLE holds 0:00 so go is moot there
        if ((state_q == S_ENTRY) && go) begin
          state_d  = S_COOK;
          presc_d  = '0;
          mag_on_d = 1'b1;
        end else if (kp) begin
          min_d   = st_q;
          st_d    = so_q;
          so_d    = key_idx;
          state_d = entry_nonzero ? S_ENTRY : S_IDLE;
        end
      end

      S_COOK: begin
        // Door/stop freezes everything, including a tick due this cycle
        if (pause_req) begin
          state_d = S_PAUSE;
        end else if (presc_q == C_TICK_LAST) begin
          presc_d = '0;
          min_d   = dec_min;
          st_d    = dec_st;
          so_d    = dec_so;
          if (dec_zero) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            mag_on_d = 1'b1;
          end
        end else begin
          presc_d  = presc_q + CNT_W'(1);
          mag_on_d = 1'b1;
        end
      end

      S_PAUSE: begin
        // Prescaler is left untouched so the partial second carries over
        if (go) begin
          state_d  = S_COOK;
          mag_on_d = 1'b1;
        end
      end

      S_DONE: begin
        min_d = 4'd0;
        st_d  = 4'd0;
        so_d  = 4'd0;
        if (bus.startn) begin
          state_d = S_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        min_d   = 4'd0;
        st_d    = 4'd0;
        so_d    = 4'd0;
        presc_d = '0;
      end
    endcase
  end

  // State register with asynchronous clear
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q    <= S_IDLE;
      min_q      <= 4'd0;
      st_q       <= 4'd0;
      so_q       <= 4'd0;
      presc_q    <= '0;
      mag_on_q   <= 1'b0;
      done_q     <= 1'b0;
      key_prev_q <= 10'd0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      st_q       <= st_d;
      so_q       <= so_d;
      presc_q    <= presc_d;
      mag_on_q   <= mag_on_d;
      done_q     <= done_d;
      key_prev_q <= key_prev_d;
    end
  end

  assign bus.mag_on       = mag_on_q;
  assign bus.min_bcd      = min_q;
  assign bus.sec_tens_bcd = st_q;
  assign bus.sec_ones_bcd = so_q;
  assign bus.done         = done_q;
  assign bus.state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_micro_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_micro_ctrl
// Brief    : Self-checking bench for micro_ctrl: directed scenarios with
//            literal expectations followed by randomized stimulus, all
//            compared every cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_micro_ctrl;

  localparam int T  = 4;
  localparam int CW = 3;

  logic clock = 1'b0;
  logic clearn;
  always #5 clock = ~clock;

  micro_ctrl_if bus ();

  micro_ctrl #(
    .TICKS_PER_SEC (T),
    .CNT_W         (CW)
  ) dut (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit run      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Time is held as whole minutes plus a 0..99 seconds field; the mode uses
  // the published state numbering; cnt counts cooking cycles into the second.
  typedef struct {
    int mode;
    int mn;
    int sc;
    int cnt;
  } mstate_t;

  mstate_t    ms;
  logic [9:0] m_prev;

  function automatic mstate_t model_next(input mstate_t s, input logic [9:0] key,
                                         input logic [9:0] prev, input logic startn,
                                         input logic stopn, input logic door);
    mstate_t n = s;
    bit kp = ($countones(key) == 1) && (prev == 10'd0);
    bit go = !startn && stopn && door;
    int idx = 0;
    for (int i = 0; i < 10; i++) if (key[i]) idx = i;
    case (s.mode)
      0, 1: begin
        if (s.mode == 1 && go) begin
          n.mode = 2;
          n.cnt  = 0;
        end else if (kp) begin
          n.mn   = s.sc / 10;
          n.sc   = (s.sc % 10) * 10 + idx;
          n.mode = (n.mn == 0 && n.sc == 0) ? 0 : 1;
        end
      end
      2: begin
        if (!door || !stopn) begin
          n.mode = 3;
        end else begin
          n.cnt = s.cnt + 1;
          if (n.cnt == T) begin
            n.cnt = 0;
            if (n.sc > 0) n.sc = n.sc - 1;
            else if (n.mn > 0) begin
              n.mn = n.mn - 1;
              n.sc = 59;
            end
            if (n.mn == 0 && n.sc == 0) n.mode = 4;
          end
        end
      end
      3: if (go) n.mode = 2;
      4: if (startn) n.mode = 0;
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  always @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      ms     <= '{0, 0, 0, 0};
      m_prev <= 10'd0;
    end else begin
      ms     <= model_next(ms, bus.keypad, m_prev, bus.startn, bus.stopn, bus.door_closed);
      m_prev <= bus.keypad;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    if (run) begin
      logic [16:0] act, exp;
      act = {bus.state, bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd, bus.mag_on, bus.done};
      exp = {3'(ms.mode), 4'(ms.mn), 4'(ms.sc / 10), 4'(ms.sc % 10),
             (ms.mode == 2), (ms.mode == 4)};
      check("model{state,min,st,so,mag,done}", 32'(act), 32'(exp));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int k);
    bus.keypad = 10'd1 << k;
    cyc(5);
    bus.keypad = 10'd0;
    cyc(2);
  endtask

  task automatic reset_pulse();
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
    cyc(1);
  endtask

  task automatic check_time(input string name, input int m, input int st, input int so);
    check({name, "_time"}, {20'd0, bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd},
          32'(m * 256 + st * 16 + so));
  endtask

  initial begin
    int r;
    clearn          = 1'b0;
    bus.keypad      = 10'd0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.door_closed = 1'b0;
    run             = 1'b1;
    cyc(2);
    check("rst_state", 32'(bus.state), 0);
    check_time("rst", 0, 0, 0);
    check("rst_mag", 32'(bus.mag_on), 0);
    check("rst_done", 32'(bus.done), 0);
    clearn = 1'b1;
    cyc(1);

    // Entry 0, 9, 9 with the door open; each held key shifts once
    press(0);
    press(9);
    check_time("entry_09", 0, 0, 9);
    press(9);
    check_time("entry_099", 0, 9, 9);
    check("entry_state", 32'(bus.state), 1);
    check("entry_mag", 32'(bus.mag_on), 0);

    // Door interlock then start
    bus.startn = 1'b0;
    cyc(3);
    check("door_open_state", 32'(bus.state), 1);
    check("door_open_mag", 32'(bus.mag_on), 0);
    bus.door_closed = 1'b1;
    cyc(1);
    check("cook_state", 32'(bus.state), 2);
    check("cook_mag", 32'(bus.mag_on), 1);
    cyc(3);
    check_time("pre_tick", 0, 9, 9);
    cyc(1);
    check_time("first_tick", 0, 9, 8);

    // Pause two cycles after a tick, then resume keeping the partial second
    cyc(2);
    bus.stopn = 1'b0;
    cyc(1);
    check("pause_state", 32'(bus.state), 3);
    check("pause_mag", 32'(bus.mag_on), 0);
    cyc(19);
    check_time("pause_frozen", 0, 9, 8);
    bus.stopn = 1'b1;
    cyc(1);
    check("resume_state", 32'(bus.state), 2);
    cyc(1);
    check_time("resume_hold", 0, 9, 8);
    cyc(1);
    check_time("resume_tick", 0, 9, 7);

    // Asynchronous clear in the middle of cooking
    @(posedge clock);
    #2 clearn = 1'b0;
    #1;
    check("async_mag", 32'(bus.mag_on), 0);
    check("async_state", 32'(bus.state), 0);
    check_time("async", 0, 0, 0);
    @(negedge clock);
    clearn = 1'b1;
    cyc(1);

    // Minute borrow 1:00 -> 0:59
    bus.startn = 1'b1;
    press(1); press(0); press(0);
    check_time("entry_100", 1, 0, 0);
    bus.startn = 1'b0;
    cyc(5);
    check_time("borrow_min", 0, 5, 9);
    reset_pulse();

    // Tens borrow 0:10 -> 0:09
    bus.startn = 1'b1;
    press(1); press(0);
    bus.startn = 1'b0;
    cyc(5);
    check_time("borrow_tens", 0, 0, 9);
    reset_pulse();

    // Completion of 0:02
    bus.startn = 1'b1;
    press(2);
    bus.startn = 1'b0;
    cyc(1);
    check("c_cook", 32'(bus.state), 2);
    cyc(7);
    check("c_still_cook", 32'(bus.state), 2);
    cyc(1);
    check("c_done_state", 32'(bus.state), 4);
    check("c_done", 32'(bus.done), 1);
    check("c_done_mag", 32'(bus.mag_on), 0);
    check_time("c_done", 0, 0, 0);
    bus.startn = 1'b1;
    cyc(1);
    check("c_idle_state", 32'(bus.state), 0);
    check("c_idle_done", 32'(bus.done), 0);

    // Multi-bit code ignored
    bus.keypad = 10'b0000000110;
    cyc(3);
    check("multibit_state", 32'(bus.state), 0);
    check_time("multibit", 0, 0, 0);
    bus.keypad = 10'd0;
    cyc(2);

    // Key press together with go: start wins, key dropped
    press(5);
    bus.keypad = 10'd1 << 3;
    bus.startn = 1'b0;
    cyc(1);
    check("kp_go_state", 32'(bus.state), 2);
    check_time("kp_go", 0, 0, 5);
    bus.keypad = 10'd0;
    reset_pulse();

    // Randomized phase checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      bus.keypad = 10'd0;
      else if (r < 75) bus.keypad = bus.keypad;
      else if (r < 95) bus.keypad = 10'd1 << $urandom_range(0, 9);
      else             bus.keypad = 10'($urandom_range(0, 1023));
      bus.startn      = ($urandom_range(0, 3) == 0);
      bus.stopn       = ($urandom_range(0, 15) != 0);
      bus.door_closed = ($urandom_range(0, 15) != 0);
      clearn          = ($urandom_range(0, 599) != 0);
      cyc(1);
    end
    clearn = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
